// File: rtl/pmci_csr_arbiter.sv
// pmci_csr_arbiter
// Two Avalon-MM masters (m0, m1) share one PMCI CSR slave port. Only one
// transaction is outstanding at a time. When both masters request together,
// the master that was not granted last wins. Reads return their data to the
// granted master through a one-cycle response register.
// Optional watchdog: define PMCI_CSR_ARB_TIMEOUT_EN to bound the time spent
// waiting in ISSUE and RSP. A read that times out completes with 32'hDEADBEEF,
// and the sticky err_timeout flag is set.
module pmci_csr_arbiter #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_timeout,
  input  logic                err_clr
);

  localparam logic [DATA_W-1:0] BAD_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2,
    RSP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              gnt;        // owner of the current transaction: 0 = m0, 1 = m1
  logic              last_gnt;   // owner of the most recent grant, for round-robin
  logic              is_wr;      // current transaction is a write
  logic              req0, req1;
  logic              sel;        // master chosen in IDLE
  logic              wr_sel;     // chosen master asks for a write (write wins over read)
  logic              load;
  logic              cap_vld_p0;
  logic              cap_bad_p0;
  logic [DATA_W-1:0] cap_data_p0;
  logic              tmo_hit;    // watchdog count has reached its limit
  logic              tmo_flag;   // current transaction was abandoned in ISSUE

  assign wr_sel      = sel ? m1_write : m0_write;
  assign cap_data_p0 = cap_bad_p0 ? BAD_DATA : s_readdata;

  // The granted master sees waitrequest low only during its ACK cycle.
  assign m0_waitrequest = !((state == ACK) && !gnt);
  assign m1_waitrequest = !((state == ACK) &&  gnt);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration, next-state and read-capture decisions.
  always_comb begin
    req0       = m0_read | m0_write;
    req1       = m1_read | m1_write;
    sel        = 1'b0;
    state_nxt  = state;
    load       = 1'b0;
    cap_vld_p0 = 1'b0;
    cap_bad_p0 = 1'b0;
    if (req0 && req1) begin
      sel = ~last_gnt;
    end else if (req1) begin
      sel = 1'b1;
    end
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // A slave accept in the same cycle as the watchdog limit still counts.
        if (!s_waitrequest) begin
          state_nxt = ACK;
        end else if (tmo_hit) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (is_wr) begin
          state_nxt = IDLE;
        end else if (tmo_flag) begin
          cap_vld_p0 = 1'b1;
          cap_bad_p0 = 1'b1;
          state_nxt  = IDLE;
        end else if (s_readdatavalid) begin
          cap_vld_p0 = 1'b1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = RSP;
        end
      end
      RSP: begin
        if (s_readdatavalid) begin
          cap_vld_p0 = 1'b1;
          state_nxt  = IDLE;
        end else if (tmo_hit) begin
          cap_vld_p0 = 1'b1;
          cap_bad_p0 = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request stage: latch the winner's fields on grant, drop strobes on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt          <= 1'b0;
      last_gnt     <= 1'b1;
      is_wr        <= 1'b0;
      s_read       <= 1'b0;
      s_write      <= 1'b0;
      s_address    <= '0;
      s_writedata  <= '0;
      s_byteenable <= '0;
    end else if (load) begin
      gnt          <= sel;
      last_gnt     <= sel;
      is_wr        <= wr_sel;
      s_write      <= wr_sel;
      s_read       <= ~wr_sel;
      s_address    <= sel ? m1_address    : m0_address;
      s_writedata  <= sel ? m1_writedata  : m0_writedata;
      s_byteenable <= sel ? m1_byteenable : m0_byteenable;
    end else if ((state == ISSUE) && (state_nxt == ACK)) begin
      s_read  <= 1'b0;
      s_write <= 1'b0;
    end
  end

  // Response stage: deliver captured read data to the owning master one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
    end else begin
      m0_readdatavalid <= cap_vld_p0 & ~gnt;
      m1_readdatavalid <= cap_vld_p0 &  gnt;
      if (cap_vld_p0 && !gnt) begin
        m0_readdata <= cap_data_p0;
      end
      if (cap_vld_p0 && gnt) begin
        m1_readdata <= cap_data_p0;
      end
    end
  end

`ifdef PMCI_CSR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_flag_q;
  logic             tmo_evt;     // watchdog actually forces completion this cycle
  logic             waiting;

  assign waiting  = (state == ISSUE) || (state == RSP);
  assign tmo_hit  = waiting && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign tmo_evt  = tmo_hit && (((state == ISSUE) && s_waitrequest) ||
                                ((state == RSP) && !s_readdatavalid));
  assign tmo_flag = tmo_flag_q;

  // Cycles spent in the current ISSUE or RSP visit; restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (waiting && (state_nxt == state)) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Remember that the slave never accepted, so ACK completes a read with BAD_DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_flag_q <= 1'b0;
    end else if (load) begin
      tmo_flag_q <= 1'b0;
    end else if ((state == ISSUE) && tmo_evt) begin
      tmo_flag_q <= 1'b1;
    end
  end

  // Sticky error flag; a new timeout takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (tmo_evt) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign tmo_hit        = 1'b0;
  assign tmo_flag       = 1'b0;
  assign err_timeout    = 1'b0;
`endif

endmodule
